// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: Hall code map, sector geometry and step classification.
// The commutation/PWM block is expected to import this package as well.
package bldc_pkg;

   localparam int SECTORS   = 6;
   localparam int ELEC_SPAN = 1024;   // position counts per electrical revolution

   typedef logic [2:0] hall_code_t;   // {c, b, a}
   typedef logic [2:0] sector_t;

   // The two codes a healthy three-sensor arrangement never produces.
   localparam hall_code_t HALL_INVALID_LO = 3'b000;
   localparam hall_code_t HALL_INVALID_HI = 3'b111;

   // Indexed by the raw {c,b,a} code; entries for the invalid codes are don't-care.
   localparam sector_t HALL_TO_SECTOR [0:7] = '{
      3'd0,   // 000 invalid
      3'd0,   // 001
      3'd2,   // 010
      3'd1,   // 011
      3'd4,   // 100
      3'd5,   // 101
      3'd3,   // 110
      3'd0    // 111 invalid
   };

   // Angle at the start of each sector, in ELEC_SPAN counts.
   localparam logic [9:0] SECTOR_BASE [0:SECTORS-1] = '{
      10'd0, 10'd171, 10'd341, 10'd512, 10'd683, 10'd853
   };

   typedef enum logic [1:0] {
      STEP_FWD,
      STEP_REV,
      STEP_JUMP
   } step_t;

   function automatic logic hall_is_valid(input hall_code_t code);
      return (code != HALL_INVALID_LO) && (code != HALL_INVALID_HI);
   endfunction

   // Relation between two valid sectors; anything not one step either way is a jump.
   function automatic step_t classify_step(input sector_t old_s, input sector_t new_s);
      sector_t fwd_s;
      sector_t rev_s;
      fwd_s = (old_s == sector_t'(SECTORS - 1)) ? 3'd0 : old_s + 3'd1;
      rev_s = (old_s == 3'd0) ? sector_t'(SECTORS - 1) : old_s - 3'd1;
      if (new_s == fwd_s)      return STEP_FWD;
      else if (new_s == rev_s) return STEP_REV;
      else                     return STEP_JUMP;
   endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Two-flop synchroniser plus stability filter for the raw Hall code.
// A new code is accepted once it has been seen unchanged for FILTER cycles;
// code_valid pulses for one cycle alongside each newly accepted code.
module hall_input_filter #(
   parameter int FILTER = 4,   // 1..255
   parameter int WIDTH  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] code,
   output logic             code_valid
);

   localparam logic [7:0] FILTER_C = 8'(FILTER);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] code_q;
   logic [7:0]       run_q;
   logic [7:0]       run_d;
   logic             valid_q;
   logic             accept;

   // Length of the current run of identical synchronised codes, saturating at FILTER.
   always_comb begin
      // NOTE: default assigned first so every path drives run_d and no latch is inferred.
      run_d = 8'd1;
      if (sync2_q == cand_q) begin
         run_d = (run_q == FILTER_C) ? run_q : run_q + 8'd1;
      end
   end

   assign accept = (sync2_q != code_q) && (run_d == FILTER_C);

   // Synchroniser, run tracking and accepted-code register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         run_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each flop samples the pre-edge value of the previous stage.
         sync1_q <= din;
         sync2_q <= sync1_q;
         cand_q  <= sync2_q;
         run_q   <= run_d;
         valid_q <= accept;
         if (accept) begin
            code_q <= sync2_q;
         end
      end
   end

   assign code       = code_q;
   assign code_valid = valid_q;

endmodule

// File: rtl/bldc_hall_decoder.sv
// Hall sensor decoder: filtered Hall code -> sector, electrical position,
// direction, edge-to-edge period and stall/error status.
module bldc_hall_decoder
   import bldc_pkg::*;
#(
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hall_a,
   input  logic        hall_b,
   input  logic        hall_c,
   output logic [15:0] feedback,
   output logic [2:0]  sector,
   output logic        direction,
   output logic [31:0] period,
   output logic        stalled,
   output logic        hall_error,
   output logic        valid
);

   localparam int         ANGLE_BITS = $clog2(ELEC_SPAN);
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

   typedef enum logic {
      ST_WAIT,   // no valid code seen since reset
      ST_RUN
   } state_t;

   state_t                     state_q, state_d;
   sector_t                    sector_q, sector_d;
   logic [15-ANGLE_BITS:0]     rev_q, rev_d;
   logic                       dir_q, dir_d;
   logic [31:0]                period_q, period_d;
   logic [31:0]                cnt_q, cnt_d;
   logic                       stalled_q, stalled_d;
   logic                       err_q, err_d;

   hall_code_t code;
   logic       code_valid;
   sector_t    new_sector;
   step_t      step;

   hall_input_filter #(
      .FILTER (FILTER),
      .WIDTH  (3)
   ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        ({hall_c, hall_b, hall_a}),
      .code       (code),
      .code_valid (code_valid)
   );

   assign new_sector = HALL_TO_SECTOR[code];
   assign step       = classify_step(sector_q, new_sector);

   // Next-state logic: timer/stall every cycle, sector tracking on each accepted code.
   always_comb begin
      state_d   = state_q;
      sector_d  = sector_q;
      rev_d     = rev_q;
      dir_d     = dir_q;
      period_d  = period_q;
      stalled_d = stalled_q;
      err_d     = err_q;
      cnt_d     = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 32'd1;

      if (cnt_q == TIMEOUT_C) begin
         stalled_d = 1'b1;
         period_d  = '0;
      end

      if (code_valid) begin
         if (!hall_is_valid(code)) begin
            // Position and timing hold; the next valid code is judged against sector_q.
            err_d = 1'b1;
         end else if (state_q == ST_WAIT) begin
            state_d   = ST_RUN;
            sector_d  = new_sector;
            rev_d     = '0;
            dir_d     = 1'b0;
            period_d  = '0;
            cnt_d     = '0;
            stalled_d = 1'b0;
            err_d     = 1'b0;
         end else begin
            sector_d = new_sector;
            cnt_d    = '0;
            unique case (step)
               STEP_FWD: begin
                  if (sector_q == sector_t'(SECTORS - 1)) rev_d = rev_q + 1'b1;
                  // A period is only meaningful between two same-direction, unstalled edges.
                  period_d  = (!dir_q && !stalled_q) ? cnt_q + 32'd1 : '0;
                  dir_d     = 1'b0;
                  stalled_d = 1'b0;
                  err_d     = 1'b0;
               end
               STEP_REV: begin
                  if (sector_q == 3'd0) rev_d = rev_q - 1'b1;
                  period_d  = (dir_q && !stalled_q) ? cnt_q + 32'd1 : '0;
                  dir_d     = 1'b1;
                  stalled_d = 1'b0;
                  err_d     = 1'b0;
               end
               default: begin
                  // Non-adjacent jump: resync the sector but keep rev and direction.
                  period_d = '0;
                  err_d    = 1'b1;
               end
            endcase
         end
      end
   end

   // Decoder state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_WAIT;
         sector_q  <= '0;
         rev_q     <= '0;
         dir_q     <= 1'b0;
         period_q  <= '0;
         cnt_q     <= '0;
         stalled_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sector_q  <= sector_d;
         rev_q     <= rev_d;
         dir_q     <= dir_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         stalled_q <= stalled_d;
         err_q     <= err_d;
      end
   end

   // rev * ELEC_SPAN + base; base < ELEC_SPAN so concatenation is the sum mod 2^16.
   assign feedback   = {rev_q, SECTOR_BASE[sector_q]};
   assign sector     = sector_q;
   assign direction  = dir_q;
   assign period     = period_q;
   assign stalled    = stalled_q;
   assign hall_error = err_q;
   assign valid      = (state_q == ST_RUN);

endmodule

// File: tb/tb_bldc_hall_decoder.sv
// Scoreboard bench for bldc_hall_decoder: stimulus pushes time-stamped expected
// outputs, a monitor pops and compares them when they fall due.
module tb_bldc_hall_decoder;

   localparam int FILTER  = 4;
   localparam int TIMEOUT = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        hall_a, hall_b, hall_c;
   logic [15:0] feedback;
   logic [2:0]  sector;
   logic        direction;
   logic [31:0] period;
   logic        stalled;
   logic        hall_error;
   logic        valid;

   bldc_hall_decoder #(
      .FILTER  (FILTER),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hall_a     (hall_a),
      .hall_b     (hall_b),
      .hall_c     (hall_c),
      .feedback   (feedback),
      .sector     (sector),
      .direction  (direction),
      .period     (period),
      .stalled    (stalled),
      .hall_error (hall_error),
      .valid      (valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      bit          at_rst;
      string       name;
      logic [15:0] fb;
      logic [2:0]  sec;
      logic        dir;
      logic [31:0] per;
      logic        stl;
      logic        err;
      logic        vld;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   t;

   task automatic expect_at(input int due, input bit at_rst, input string name,
                            input int fb, input int sec, input bit dir, input int per,
                            input bit stl, input bit err, input bit vld);
      exp_t e;
      e.due    = at_rst ? 32'h7fff_ffff : due;
      e.at_rst = at_rst;
      e.name   = name;
      e.fb     = 16'(fb);
      e.sec    = 3'(sec);
      e.dir    = dir;
      e.per    = 32'(per);
      e.stl    = stl;
      e.err    = err;
      e.vld    = vld;
      sb.push_back(e);
   endtask

   task automatic check(input exp_t e);
      n_checks++;
      if (feedback !== e.fb || sector !== e.sec || direction !== e.dir || period !== e.per ||
          stalled !== e.stl || hall_error !== e.err || valid !== e.vld) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got fb=%0d sec=%0d dir=%0d per=%0d stl=%0d err=%0d vld=%0d ; want fb=%0d sec=%0d dir=%0d per=%0d stl=%0d err=%0d vld=%0d",
                  e.name, cyc, feedback, sector, direction, period, stalled, hall_error, valid,
                  e.fb, e.sec, e.dir, e.per, e.stl, e.err, e.vld);
      end
   endtask

   // Monitor: compares due entries just after each falling clock edge, and reset
   // entries just after rst_n falls (before any rising clock edge).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         while (sb.size() > 0 && (sb[0].at_rst ? !rst_n : (sb[0].due <= cyc))) begin
            e = sb.pop_front();
            check(e);
         end
      end
   end

   task automatic drive(input logic [2:0] code);
      {hall_c, hall_b, hall_a} = code;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A pin change applied at a falling edge reaches the outputs FILTER+3 rising edges later.
   localparam int LAT = FILTER + 3;

   initial begin
      int budget;
      exp_t e;

      drive(3'b001);
      expect_at(0, 1, "reset_initial", 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;

      wait_neg(3);
      rst_n = 1'b1;
      t = cyc;
      expect_at(t + LAT - 1, 0, "pre_accept",  0, 0, 0, 0, 0, 0, 0);
      expect_at(t + LAT,     0, "first_code",  0, 0, 0, 0, 0, 0, 1);

      // Forward rotation, checking every sector and the 5->0 wrap.
      wait_neg(100); drive(3'b011); t = cyc;
      expect_at(t + LAT, 0, "fwd_s1",   171, 1, 0, 100, 0, 0, 1);
      wait_neg(100); drive(3'b010); t = cyc;
      expect_at(t + LAT, 0, "fwd_s2",   341, 2, 0, 100, 0, 0, 1);
      wait_neg(50);  drive(3'b110); t = cyc;
      expect_at(t + LAT, 0, "fwd_s3",   512, 3, 0, 50, 0, 0, 1);
      wait_neg(50);  drive(3'b100); t = cyc;
      expect_at(t + LAT, 0, "fwd_s4",   683, 4, 0, 50, 0, 0, 1);
      wait_neg(50);  drive(3'b101); t = cyc;
      expect_at(t + LAT, 0, "fwd_s5",   853, 5, 0, 50, 0, 0, 1);
      wait_neg(50);  drive(3'b001); t = cyc;
      expect_at(t + LAT, 0, "fwd_wrap", 1024, 0, 0, 50, 0, 0, 1);

      // Reversal: rev steps back, period unknown on the turn, then measured.
      wait_neg(50);  drive(3'b101); t = cyc;
      expect_at(t + LAT, 0, "rev_turn", 853, 5, 1, 0, 0, 0, 1);
      wait_neg(60);  drive(3'b100); t = cyc;
      expect_at(t + LAT, 0, "rev_s4",   683, 4, 1, 60, 0, 0, 1);

      // 2-cycle glitch to 000 is filtered out.
      wait_neg(60);  drive(3'b000);
      wait_neg(2);   drive(3'b100); t = cyc;
      expect_at(t + 10, 0, "glitch_ignored", 683, 4, 1, 60, 0, 0, 1);

      // Sustained invalid code flags an error but holds position and timing.
      wait_neg(10);  drive(3'b000); t = cyc;
      expect_at(t + LAT, 0, "invalid_hold", 683, 4, 1, 60, 0, 1, 1);
      // Recovery measured from the last valid edge (92 cycles earlier).
      wait_neg(20);  drive(3'b110); t = cyc;
      expect_at(t + LAT, 0, "recover_s3", 512, 3, 1, 92, 0, 0, 1);

      // Non-adjacent jump 3->5, then an adjacent step clears the error.
      wait_neg(40);  drive(3'b101); t = cyc;
      expect_at(t + LAT, 0, "jump_s5",    853, 5, 1, 0, 0, 1, 1);
      wait_neg(40);  drive(3'b100); t = cyc;
      expect_at(t + LAT, 0, "after_jump", 683, 4, 1, 40, 0, 0, 1);

      // Stall boundary: still running at cnt==TIMEOUT, stalled the cycle after.
      expect_at(t + LAT + TIMEOUT,     0, "pre_stall", 683, 4, 1, 40, 0, 0, 1);
      expect_at(t + LAT + TIMEOUT + 1, 0, "stall",     683, 4, 1, 0, 1, 0, 1);
      wait_neg(TIMEOUT + 20); drive(3'b110); t = cyc;
      expect_at(t + LAT, 0, "unstall", 512, 3, 1, 0, 0, 0, 1);
      wait_neg(30);  drive(3'b010); t = cyc;
      expect_at(t + LAT, 0, "rev_s2",  341, 2, 1, 30, 0, 0, 1);

      // Asynchronous reset mid-operation, away from any rising edge.
      wait_neg(20);
      expect_at(0, 1, "reset_midop", 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      wait_neg(3);   drive(3'b001);
      wait_neg(2);   rst_n = 1'b1; t = cyc;
      expect_at(t + LAT, 0, "first_after_reset", 0, 0, 0, 0, 0, 0, 1);
      // Reverse from reset state wraps rev to 63.
      wait_neg(50);  drive(3'b101); t = cyc;
      expect_at(t + LAT, 0, "rev_wrap", 65365, 5, 1, 0, 0, 0, 1);

      // Drain the scoreboard with a bounded wait.
      budget = 0;
      while (sb.size() > 0 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s: never compared (timeout), want fb=%0d sec=%0d", e.name, e.fb, e.sec);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
